obstacle_selector: RTL and testbench
====================================

OBSTACLE_SELECTOR -- requirements
Module: obstacle_selector

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 60, meaning the number of idle cycles between two obstacles (minimum 1).
REQ-002 The block SHALL have parameter RUN_TIMEOUT, default 600, meaning the maximum number of cycles one obstacle may stay active (minimum 2).
REQ-003 The block SHALL have parameter LFSR_SEED, default 8'hA5, meaning the nonzero LFSR value loaded at reset.
REQ-004 pclk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 game_start  input  1  one-cycle pulse that starts a game.
REQ-007 game_over  input  1  level signal; while high, the game is stopped.
REQ-008 obstacle_done  input  1  pulse from the active obstacle generator indicating that the obstacle has finished.
REQ-009 select  output  3  index into the downstream 7:1 obstacle mux; 0 = no obstacle, 1..6 = obstacle generators; registered.
REQ-010 obstacle_start  output  1  one-cycle pulse that restarts the newly selected obstacle generator; registered.
REQ-011 timeout  output  1  one-cycle pulse indicating that an obstacle was aborted by RUN_TIMEOUT; registered.
REQ-012 round_count  output  8  number of obstacles completed in the current game; registered.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, PICK, RUN and GAP.
REQ-015 In IDLE, when game_start=1 and game_over=0, the block SHALL go to PICK on the next edge and clear round_count to 0.
REQ-016 PICK SHALL last exactly one cycle; at its end, select SHALL load the picked index, obstacle_start SHALL be 1 for the following cycle only, and the state SHALL become RUN.
REQ-017 The pick SHALL be cand = (lfsr mod 6) + 1, where lfsr is its value in the PICK cycle; if cand equals prev_sel, then pick = (cand mod 6) + 1, otherwise pick = cand.
REQ-018 The picked index SHALL always lie in 1..6 and SHALL always differ from prev_sel.
REQ-019 prev_sel SHALL be an internal register, reset to 0 and updated with each pick.
REQ-020 The LFSR SHALL be 8-bit Fibonacci, with taps 8,6,5,4 and shift-left, and SHALL advance every cycle when rst=0.
REQ-021 The LFSR value SHALL never be 0.
REQ-022 RUN SHALL hold select and count its cycles with run_cnt, which is 0 in the first RUN cycle.
REQ-023 obstacle_done SHALL be honoured in every RUN cycle, including the first one.
REQ-024 In RUN, when obstacle_done=1, the next edge SHALL set select=0, increment round_count (saturating at 255) and change the state to GAP.
REQ-025 In RUN, when run_cnt = RUN_TIMEOUT-1 and obstacle_done=0, the next edge SHALL set select=0, pulse timeout for one cycle, change the state to GAP and leave round_count unchanged.
REQ-026 When obstacle_done and the timeout condition coincide, the done case SHALL apply and timeout SHALL stay 0.
REQ-027 GAP SHALL hold select=0 for exactly GAP_CYCLES cycles and then go to PICK.
REQ-028 obstacle_done SHALL be ignored in GAP, PICK and IDLE.
REQ-029 game_over=1 in any state SHALL force IDLE on the next edge with select=0 and obstacle_start=0.
REQ-030 On game_over, round_count SHALL hold its value, so the score remains readable.
REQ-031 When game_start and game_over are high together, game_over SHALL win.
REQ-032 game_start SHALL be ignored outside IDLE.
REQ-033 obstacle_start and timeout SHALL never be high in the same cycle.
REQ-034 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-035 rst=1 SHALL, on the next edge and regardless of state, set: state=IDLE, select=0, obstacle_start=0, timeout=0, round_count=0, busy=0, prev_sel=0, all counters=0 and lfsr=LFSR_SEED.
REQ-036 Reset SHALL take precedence over all other inputs, including during RUN or GAP.

Verification (GAP_CYCLES=4, RUN_TIMEOUT=16)
REQ-037 Reset then game_start at cycle N -> select=0 through cycle N+1; at cycle N+2, select in 1..6, equal to the model pick, and obstacle_start=1; at N+3, obstacle_start=0; busy=1 from N+1.
REQ-038 obstacle_done in the 3rd RUN cycle -> next cycle select=0 and round_count=1; select stays 0 for 4 cycles, then 1 PICK cycle; the new select differs from the previous one and obstacle_start pulses once.
REQ-039 obstacle_done never asserted -> after 16 RUN cycles select=0, timeout=1 for one cycle and round_count unchanged; force a pick collision via LFSR_SEED and check the (cand mod 6)+1 fallback.
REQ-040 game_over in mid-RUN and mid-GAP, and game_start+game_over together in IDLE -> next cycle IDLE, select=0, busy=0, round_count held; no PICK occurs.
REQ-041 rst during RUN with select=5 -> next cycle all outputs are at their reset values; 300 back-to-back rounds -> round_count saturates at 255, picks stay in 1..6 with no repeats, and the LFSR never reaches 0.

Source files
------------

// File: rtl/obstacle_selector.sv
// Obstacle sequencer: picks a pseudo-random obstacle generator (1..6, never the same twice in a
// row), runs it until done or timeout, idles for a fixed gap, and counts completed obstacles.
module obstacle_selector #(
  parameter int unsigned GAP_CYCLES  = 60,
  parameter int unsigned RUN_TIMEOUT = 600,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       obstacle_done,
  output logic [2:0] select,
  output logic       obstacle_start,
  output logic       timeout,
  output logic [7:0] round_count,
  output logic       busy
);

  localparam int unsigned RunW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam logic [RunW-1:0] RunLast = RunW'(RUN_TIMEOUT - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPick, StRun, StGap} state_e;

  state_e          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [2:0]      prev_q, prev_d;
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]      select_q, select_d;
  logic            start_q, start_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      round_q, round_d;
  logic [2:0]      cand, pick;

  // Maximal-length taps keep a nonzero seed away from the all-zero lockup state.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    cand = 3'(lfsr_q % 8'd6) + 3'd1;
    if (cand == prev_q) begin
      pick = (cand == 3'd6) ? 3'd1 : cand + 3'd1;
    end else begin
      pick = cand;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (game_over) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (game_start) state_d = StPick;
        StPick:  state_d = StRun;
        StRun:   if (obstacle_done || (run_cnt_q == RunLast)) state_d = StGap;
        StGap:   if (gap_cnt_q == GapLast) state_d = StPick;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    select_d  = select_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    round_d   = round_q;
    prev_d    = prev_q;
    run_cnt_d = run_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (game_over) begin
      // Score is left untouched so it stays readable after the game ends.
      select_d  = 3'd0;
      run_cnt_d = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          select_d = 3'd0;
          if (game_start) round_d = 8'd0;
        end
        StPick: begin
          select_d  = pick;
          prev_d    = pick;
          start_d   = 1'b1;
          run_cnt_d = '0;
        end
        StRun: begin
          if (obstacle_done) begin
            select_d  = 3'd0;
            round_d   = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
            gap_cnt_d = '0;
          end else if (run_cnt_q == RunLast) begin
            select_d  = 3'd0;
            timeout_d = 1'b1;
            gap_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + RunW'(1);
          end
        end
        StGap: begin
          select_d  = 3'd0;
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
        default: select_d = 3'd0;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      lfsr_q    <= LFSR_SEED;
      prev_q    <= 3'd0;
      run_cnt_q <= '0;
      gap_cnt_q <= '0;
      select_q  <= 3'd0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      round_q   <= 8'd0;
    end else begin
      lfsr_q    <= lfsr_d;
      prev_q    <= prev_d;
      run_cnt_q <= run_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      select_q  <= select_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      round_q   <= round_d;
    end
  end

  assign select         = select_q;
  assign obstacle_start = start_q;
  assign timeout        = timeout_q;
  assign round_count    = round_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_obstacle_selector.sv
// Directed bench for obstacle_selector with GAP_CYCLES=4, RUN_TIMEOUT=16, seed 8'hA5.
module tb_obstacle_selector;

  localparam int unsigned GapCycles  = 4;
  localparam int unsigned RunTimeout = 16;
  localparam logic [7:0]  Seed       = 8'hA5;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       game_start = 1'b0;
  logic       game_over = 1'b0;
  logic       obstacle_done = 1'b0;
  logic [2:0] select;
  logic       obstacle_start;
  logic       timeout;
  logic [7:0] round_count;
  logic       busy;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_lfsr;
  logic [2:0] m_prev = 3'd0;
  logic [2:0] exp_sel;
  logic [2:0] last_sel;

  obstacle_selector #(
    .GAP_CYCLES (GapCycles),
    .RUN_TIMEOUT(RunTimeout),
    .LFSR_SEED  (Seed)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .game_start    (game_start),
    .game_over     (game_over),
    .obstacle_done (obstacle_done),
    .select        (select),
    .obstacle_start(obstacle_start),
    .timeout       (timeout),
    .round_count   (round_count),
    .busy          (busy)
  );

  always #5 pclk = ~pclk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [2:0] model_pick(input logic [7:0] l, input logic [2:0] p);
    int c;
    c = (int'(l) % 6) + 1;
    if (c == int'(p)) c = (c % 6) + 1;
    return 3'(c);
  endfunction

  // Reference LFSR follows the bench's own reset.
  always @(posedge pclk) m_lfsr <= rst ? Seed : lfsr_step(m_lfsr);

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Call right after ticking into PICK.
  task automatic note_pick();
    exp_sel = model_pick(m_lfsr, m_prev);
    m_prev  = exp_sel;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    game_start    = 1'b0;
    game_over     = 1'b0;
    obstacle_done = 1'b0;
    tick();
    tick();
    m_prev = 3'd0;
  endtask

  initial begin
    // Reset state, first pick, done in 3rd RUN cycle
    do_reset();
    check("rst_select", select, 0);
    check("rst_start", obstacle_start, 0);
    check("rst_timeout", timeout, 0);
    check("rst_round", round_count, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    note_pick();
    check("pick_busy", busy, 1);
    check("pick_sel0", select, 0);
    check("pick_start0", obstacle_start, 0);
    tick();
    check("run1_sel", select, 3);
    check("run1_start", obstacle_start, 1);
    tick();
    check("run2_sel", select, 3);
    check("run2_start", obstacle_start, 0);
    tick();
    obstacle_done = 1'b1;
    tick();
    check("done_sel0", select, 0);
    check("done_round", round_count, 1);
    check("done_timeout", timeout, 0);
    // done stays high through GAP and PICK and must be ignored
    repeat (3) begin
      tick();
      check("gap_sel0", select, 0);
      check("gap_round", round_count, 1);
      check("gap_busy", busy, 1);
    end
    tick();
    note_pick();
    check("pick2_sel0", select, 0);
    check("pick2_start0", obstacle_start, 0);
    tick();
    obstacle_done = 1'b0;
    check("pick2_sel", select, 2);
    check("pick2_start", obstacle_start, 1);
    check("pick2_round", round_count, 1);

    // Timeout after 16 RUN cycles
    repeat (15) tick();
    check("run16_sel", select, 2);
    check("run16_timeout", timeout, 0);
    tick();
    check("to_sel0", select, 0);
    check("to_pulse", timeout, 1);
    check("to_round", round_count, 1);
    check("to_start", obstacle_start, 0);
    tick();
    check("to_clear", timeout, 0);
    repeat (2) tick();
    tick();
    note_pick();
    tick();
    check("pick3_sel", select, 32'(exp_sel));
    check("pick3_start", obstacle_start, 1);

    // game_over mid-RUN, then start+over together in IDLE
    tick();
    game_over = 1'b1;
    tick();
    check("over_run_sel", select, 0);
    check("over_run_busy", busy, 0);
    check("over_run_start", obstacle_start, 0);
    check("over_run_round", round_count, 1);
    game_start = 1'b1;
    tick();
    check("both_busy", busy, 0);
    check("both_sel", select, 0);
    check("both_round", round_count, 1);
    game_over = 1'b0;
    game_start = 1'b0;
    tick();
    tick();
    check("idle_busy", busy, 0);
    check("idle_start", obstacle_start, 0);

    // game_over mid-GAP
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    note_pick();
    check("restart_round", round_count, 0);
    check("restart_busy", busy, 1);
    tick();
    check("restart_sel", select, 32'(exp_sel));
    obstacle_done = 1'b1;
    tick();
    obstacle_done = 1'b0;
    check("restart_done_round", round_count, 1);
    tick();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("over_gap_busy", busy, 0);
    check("over_gap_sel", select, 0);
    check("over_gap_round", round_count, 1);
    repeat (6) tick();
    check("over_gap_nopick", busy, 0);
    check("over_gap_nosel", select, 0);

    // Forced pick collision: cand 3 against prev 3 falls back to 4
    do_reset();
    rst = 1'b0;
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    note_pick();
    tick();
    check("coll_first", select, 3);
    repeat (9) tick();
    obstacle_done = 1'b1;
    tick();
    obstacle_done = 1'b0;
    repeat (4) tick();
    note_pick();
    tick();
    check("coll_fallback", select, 4);

    // Reset during RUN with select=5
    do_reset();
    rst = 1'b0;
    repeat (11) tick();
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    note_pick();
    tick();
    check("sel5", select, 5);
    tick();
    rst = 1'b1;
    tick();
    m_prev = 3'd0;
    check("rr_sel", select, 0);
    check("rr_start", obstacle_start, 0);
    check("rr_timeout", timeout, 0);
    check("rr_round", round_count, 0);
    check("rr_busy", busy, 0);
    rst = 1'b0;
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    note_pick();
    tick();
    check("rr_first_pick", select, 3);

    // 300 back-to-back rounds, done in the first RUN cycle
    for (int r = 1; r <= 300; r++) begin
      last_sel = select;
      obstacle_done = 1'b1;
      tick();
      obstacle_done = 1'b0;
      check("sat_round", round_count, (r > 255) ? 255 : r);
      repeat (4) tick();
      note_pick();
      tick();
      check("long_sel", select, 32'(exp_sel));
      check("long_norepeat", 32'(select != last_sel), 1);
      check("long_range", 32'((select >= 3'd1) && (select <= 3'd6)), 1);
    end
    check("final_round", round_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
